board_scheduler: RTL and testbench

Owns the 20×10 Tetris playfield storage and shares its single access slot between the VGA renderer and the game logic. Display lookups, indexed by the cell coordinates from the pixel-to-cell mapper, get every `ce` cycle. Game commands (row read, piece merge, line clear with compaction, wipe) run only in non-`ce` cycles. The block sits between the cell mapper and pixel colour logic on the display side, and the game FSM on the command side.

---
 rtl/board_scheduler.sv | 173 +++++++++++++++++
 tb/tb_board_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_scheduler.sv
// Tetris 20x10 playfield store: display lookups get every ce slot, game commands use ce=0 slots.
// Latency: cell_on 1 edge after a ce edge; READ/MERGE/WIPE respond after 1 command slot, CLEAR_LINES after 1+ROWS+k slots.
// Backpressure: cmd_ready only in IDLE; held-high ce stalls a running command with busy=1.
// Optional feature: define BOARD_SCHED_LINE_CLEAR_EN to enable CLEAR_LINES compaction.
module board_scheduler #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [3:0]      x_b,
  input  logic [4:0]      y_b,
  input  logic            in_field,
  output logic            cell_on,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_row,
  input  logic [COLS-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_err,
  output logic [4:0]      lines_cleared,
  output logic            busy
);

  localparam logic [4:0] ROW_LIM  = 5'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [3:0] COL_LIM  = 4'(COLS);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_MERGE = 2'b01;
  localparam logic [1:0] OP_WIPE  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SCAN, S_FILL, S_RESP} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [4:0]      row_q;
  logic [COLS-1:0] data_q;
  logic [COLS-1:0] board [ROWS];

`ifdef BOARD_SCHED_LINE_CLEAR_EN
  logic [4:0] src;
  logic [4:0] dst;
  logic [4:0] count;
  logic       scan_full;
  logic [4:0] count_nxt;

  // A full source row is dropped; the drop count decides FILL vs RESP after row 0.
  assign scan_full = &board[src];
  assign count_nxt = scan_full ? count + 5'd1 : count;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Display lookup: sample the addressed cell on ce edges, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cell_on <= 1'b0;
    end else if (ce) begin
      cell_on <= (in_field && (x_b < COL_LIM) && (y_b < ROW_LIM)) ? board[y_b][x_b] : 1'b0;
    end
  end

  // Command FSM and board writes; row work only happens in ce=0 slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      op_q          <= 2'b00;
      row_q         <= 5'd0;
      data_q        <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      lines_cleared <= 5'd0;
      for (int i = 0; i < ROWS; i++) board[i] <= '0;
`ifdef BOARD_SCHED_LINE_CLEAR_EN
      src           <= 5'd0;
      dst           <= 5'd0;
      count         <= 5'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            row_q  <= cmd_row;
            data_q <= cmd_data;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!ce) begin
            case (op_q)
              OP_READ, OP_MERGE: begin
                if (row_q < ROW_LIM) begin
                  if (op_q == OP_MERGE) board[row_q] <= board[row_q] | data_q;
                  rsp_data <= board[row_q] | ((op_q == OP_MERGE) ? data_q : '0);
                  rsp_err  <= 1'b0;
                end else begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                end
                state <= S_RESP;
              end
              OP_WIPE: begin
                for (int i = 0; i < ROWS; i++) board[i] <= '0;
                rsp_data <= '0;
                rsp_err  <= 1'b0;
                state    <= S_RESP;
              end
              default: begin
                rsp_data <= '0;
`ifdef BOARD_SCHED_LINE_CLEAR_EN
                // Compaction walks bottom-up; this slot only primes the pointers.
                rsp_err <= 1'b0;
                src     <= LAST_ROW;
                dst     <= LAST_ROW;
                count   <= 5'd0;
                state   <= S_SCAN;
`else
                rsp_err       <= 1'b1;
                lines_cleared <= 5'd0;
                state         <= S_RESP;
`endif
              end
            endcase
          end
        end
`ifdef BOARD_SCHED_LINE_CLEAR_EN
        S_SCAN: begin
          if (!ce) begin
            if (scan_full) begin
              count <= count_nxt;
            end else begin
              board[dst] <= board[src];
              dst        <= dst - 5'd1;
            end
            // Compare before decrementing so src never wraps into a bogus row.
            if (src == 5'd0) begin
              if (count_nxt == 5'd0) begin
                lines_cleared <= 5'd0;
                state         <= S_RESP;
              end else begin
                state <= S_FILL;
              end
            end else begin
              src <= src - 5'd1;
            end
          end
        end
        S_FILL: begin
          if (!ce) begin
            board[dst] <= '0;
            if (dst == 5'd0) begin
              lines_cleared <= count;
              state         <= S_RESP;
            end else begin
              dst <= dst - 5'd1;
            end
          end
        end
`endif
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scheduler.sv
module tb_board_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic [3:0] x_b = 4'd0;
  logic [4:0] y_b = 5'd0;
  logic       in_field = 1'b0;
  logic       cell_on;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_row = 5'd0;
  logic [9:0] cmd_data = 10'd0;
  logic       rsp_valid;
  logic [9:0] rsp_data;
  logic       rsp_err;
  logic [4:0] lines_cleared;
  logic       busy;

  board_scheduler #(.ROWS(20), .COLS(10)) dut (
    .clk(clk), .reset(reset), .ce(ce), .x_b(x_b), .y_b(y_b), .in_field(in_field),
    .cell_on(cell_on), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .lines_cleared(lines_cleared), .busy(busy)
  );

  always #5 clk = ~clk;

  // ce is one cycle in four unless held high to stall command work.
  logic ce_hold = 1'b0;
  int   ce_cnt = 0;
  always @(negedge clk) begin
    ce_cnt = ce_cnt + 1;
    ce = ce_hold | (ce_cnt[1:0] == 2'd0);
  end

  typedef struct packed {
    logic [9:0]  d;
    logic        e;
    logic [31:0] slots;
    logic [4:0]  lines;
    logic        is_clr;
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] model [20];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cell_on"}, cell_on, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_lines"}, lines_cleared, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Push the expected response, run the handshake, then pop and compare on rsp_valid.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [9:0] data,
                         input int stall);
    exp_t       e;
    exp_t       got_e;
    logic [9:0] nb [20];
    int         k;
    int         j;
    int         w;
    int         slots;
    int         extra;
    bit         got;
    e = '{d: 10'd0, e: 1'b0, slots: 32'd1, lines: 5'd0, is_clr: 1'b0};
    case (op)
      2'b00: if (row < 20) e.d = model[row]; else e.e = 1'b1;
      2'b01: if (row < 20) begin model[row] = model[row] | data; e.d = model[row]; end
             else e.e = 1'b1;
      2'b11: for (int i = 0; i < 20; i++) model[i] = 10'd0;
      default: begin
        e.is_clr = 1'b1;
`ifdef BOARD_SCHED_LINE_CLEAR_EN
        k = 0;
        j = 19;
        for (int i = 19; i >= 0; i--) begin
          if (model[i] == 10'h3FF) k++;
          else begin nb[j] = model[i]; j--; end
        end
        for (int i = 0; i <= j; i++) nb[i] = 10'd0;
        for (int i = 0; i < 20; i++) model[i] = nb[i];
        e.lines = 5'(k);
        e.slots = 32'(21 + k);
`else
        e.e = 1'b1;
`endif
      end
    endcase
    sb_q.push_back(e);

    if (stall > 0) ce_hold = 1'b1;
    cmd_op = op; cmd_row = row; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    if (stall > 0) begin
      // A competing WIPE while busy must be ignored.
      cmd_op = 2'b11; cmd_valid = 1'b1;
      for (int c = 0; c < stall; c++) begin
        chk("stall_busy", busy, 1);
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_rsp_valid", rsp_valid, 0);
        @(negedge clk);
      end
      ce_hold = 1'b0;
    end
    cmd_valid = 1'b0;

    slots = 0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk);
      if (!ce) slots++;
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      chk("rsp_timeout", 0, 1);
    end else begin
      got_e = sb_q.pop_front();
      chk("rsp_data", rsp_data, got_e.d);
      chk("rsp_err", rsp_err, got_e.e);
      chk("cmd_slots", slots, got_e.slots);
      @(negedge clk);
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("ready_after_rsp", cmd_ready, 1);
      if (got_e.is_clr) chk("lines_cleared", lines_cleared, got_e.lines);
    end
    if (stall > 0) begin
      extra = 0;
      repeat (12) begin @(negedge clk); if (rsp_valid) extra++; end
      chk("no_extra_rsp", extra, 0);
    end
  endtask

  // Drive a display lookup, wait for a ce edge, compare cell_on with the model.
  task automatic disp(input logic [3:0] x, input logic [4:0] y, input logic inf, input string tag);
    logic [9:0] r;
    logic       exp;
    int         w;
    exp = 1'b0;
    if (inf && x < 10 && y < 20) begin r = model[y]; exp = r[x]; end
    x_b = x; y_b = y; in_field = inf;
    w = 0;
    @(posedge clk);
    while (!ce && w < 20) begin @(posedge clk); w++; end
    @(negedge clk);
    chk(tag, cell_on, exp);
  endtask

  task automatic read_all();
    for (int r = 0; r < 20; r++) run_cmd(2'b00, 5'(r), 10'd0, 0);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) model[i] = 10'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    reset = 1'b1;
    @(negedge clk);

    // MERGE then READ, and display lookups around the written cell
    run_cmd(2'b01, 5'd19, 10'h3FF, 0);
    run_cmd(2'b00, 5'd19, 10'd0, 0);
    disp(4'd4, 5'd19, 1'b1, "disp_hit");
    disp(4'd4, 5'd19, 1'b0, "disp_not_in_field");
    disp(4'd10, 5'd19, 1'b1, "disp_x_range");
    disp(4'd4, 5'd18, 1'b1, "disp_empty_row");
    run_cmd(2'b01, 5'd5, 10'h300, 0);
    run_cmd(2'b01, 5'd5, 10'h00C, 0);
    disp(4'd2, 5'd5, 1'b1, "disp_or_merge");

    // Out-of-range rows
    run_cmd(2'b11, 5'd0, 10'd0, 0);
    run_cmd(2'b01, 5'd20, 10'h001, 0);
    run_cmd(2'b00, 5'd25, 10'd0, 0);
    disp(4'd0, 5'd20, 1'b1, "disp_y_range");
    read_all();

    // Line clear with compaction
    run_cmd(2'b01, 5'd19, 10'h3FF, 0);
    run_cmd(2'b01, 5'd18, 10'h201, 0);
    run_cmd(2'b01, 5'd17, 10'h3FF, 0);
    run_cmd(2'b01, 5'd16, 10'h00F, 0);
    run_cmd(2'b10, 5'd0, 10'd0, 0);
    read_all();

    // Busy handling with a full top row and ce held high
    run_cmd(2'b01, 5'd0, 10'h3FF, 0);
    run_cmd(2'b01, 5'd10, 10'h155, 0);
    run_cmd(2'b10, 5'd0, 10'd0, 50);
    read_all();

    // Reset in the middle of a running command
    run_cmd(2'b01, 5'd19, 10'h3FF, 0);
    run_cmd(2'b00, 5'd19, 10'd0, 0);
    disp(4'd0, 5'd19, 1'b1, "disp_pre_reset");
`ifdef BOARD_SCHED_LINE_CLEAR_EN
    ce_hold = 1'b0;
`else
    ce_hold = 1'b1;
`endif
    cmd_op = 2'b10; cmd_row = 5'd0; cmd_data = 10'd0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_cmd");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ce_hold = 1'b0;
    for (int i = 0; i < 20; i++) model[i] = 10'd0;
    @(negedge clk);
    chk("idle_after_reset", busy, 0);
    disp(4'd0, 5'd19, 1'b1, "disp_after_reset");
    read_all();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
